// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch: program counter and fetch stage sitting in front of the
// instruction ROM. Drives the ROM chip-enable and word address, captures the
// ROM's combinational read data into the IF/ID register, and handles stall,
// branch/jump redirect (MIPS delay slot kept) and flush.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   stall      in   hold PC and IF/ID this cycle
//   flush      in   turn IF/ID into a bubble this cycle (wins over stall)
//   br_taken   in   redirect PC to br_target at this edge
//   br_target  in   redirect address, bits [1:0] ignored
//   rom_ce     out  ROM chip-enable, high once out of BOOT
//   rom_addr   out  ROM word address, pc[ROM_ADDR_W+1:2]
//   rom_data   in   ROM read data, combinational from rom_addr
//   if_pc      out  PC of the instruction held in IF/ID
//   if_inst    out  instruction held in IF/ID
//   if_valid   out  IF/ID holds a real instruction
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter int unsigned     PC_W       = 32,
    parameter int unsigned     ROM_ADDR_W = 10,
    parameter int unsigned     INST_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  br_taken,
    input  logic [PC_W-1:0]       br_target,
    output logic                  rom_ce,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0]     rom_data,
    output logic [PC_W-1:0]       if_pc,
    output logic [INST_W-1:0]     if_inst,
    output logic                  if_valid
);

    // BOOT gives the ROM one idle cycle after reset before it is enabled.
    localparam logic StBoot = 1'b0;
    localparam logic StRun  = 1'b1;

    logic              state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   if_pc_q, if_pc_d;
    logic [INST_W-1:0] if_inst_q, if_inst_d;
    logic              if_valid_q, if_valid_d;

    // Redirects are always word aligned; the low target bits are dropped.
    logic unused_br_lo;
    assign unused_br_lo = ^br_target[1:0];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;

        if (state_q == StBoot) begin
            // rom_data may be Z here; keep IF/ID a bubble and PC untouched.
            state_d    = StRun;
            if_inst_d  = '0;
            if_valid_d = 1'b0;
        end else begin
            // A branch arriving under stall is dropped; the requester holds it.
            if (!stall) begin
                if (br_taken) begin
                    pc_d = {br_target[PC_W-1:2], 2'b00};
                end else begin
                    pc_d = pc_q + PC_W'(4);
                end
            end

            if (flush) begin
                if_inst_d  = '0;
                if_valid_d = 1'b0;
                if_pc_d    = pc_q;
            end else if (!stall) begin
                // Also captures the delay slot when a branch is accepted.
                if_inst_d  = rom_data;
                if_valid_d = 1'b1;
                if_pc_d    = pc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign rom_ce   = (state_q == StRun);
    assign rom_addr = pc_q[ROM_ADDR_W+1:2];
    assign if_pc    = if_pc_q;
    assign if_inst  = if_inst_q;
    assign if_valid = if_valid_q;

endmodule
